// File: rtl/l15_data_refill_writer.sv
// l15_data_refill_writer
//   Collects refill beats into full data-RAM words and writes each word to
//   the single-ported data SRAM. Lookup reads share the same port. A refill
//   write always wins, and a refused read is retried by its requester.
//
//   Ports
//     clk, rst_n                         clock, async active-low reset
//     refill_req_i/gnt_o, refill_addr_i  start of a line refill (line address)
//     beat_valid_i/ready_o, beat_data_i, beat_err_i   refill beat stream
//     rd_req_i/gnt_o, rd_addr_i          lookup read request
//     mem_req/write/addr/wdata/be_o      data SRAM port
//     refill_done_o, refill_err_o        end-of-line pulse and its error flag
//     busy_o                             refill in progress

// One beat-wide slice of the assembly buffer.
module l15_refill_beat_slice #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
endmodule

module l15_data_refill_writer #(
  parameter int DATA_WIDTH     = 128,
  parameter int BEAT_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 7,
  parameter int WORDS_PER_LINE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    refill_req_i,
  output logic                    refill_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   refill_addr_i,
  input  logic                    beat_valid_i,
  output logic                    beat_ready_o,
  input  logic [BEAT_WIDTH-1:0]   beat_data_i,
  input  logic                    beat_err_i,
  input  logic                    rd_req_i,
  output logic                    rd_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    mem_req_o,
  output logic                    mem_write_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic                    refill_done_o,
  output logic                    refill_err_o,
  output logic                    busy_o
);
  localparam int RATIO  = DATA_WIDTH / BEAT_WIDTH;
  localparam int LW     = $clog2(WORDS_PER_LINE);     // word-in-line bits, 0 for 1 word/line
  localparam int WCW    = (LW > 0) ? LW : 1;
  localparam int BCW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BASE_W = ADDR_WIDTH - LW;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t                            state, state_d;
  logic [BASE_W-1:0]                 base;
  logic [BCW-1:0]                    beat_cnt;
  logic [WCW-1:0]                    word_cnt;
  logic                              err;
  logic [RATIO-1:0][BEAT_WIDTH-1:0]  buffer;   // beat 0 in the LSBs
  logic [ADDR_WIDTH-1:0]             wr_addr;
  logic                              beat_acc, last_beat, last_word;

  assign beat_acc  = beat_valid_i && (state == COLLECT);
  assign last_beat = (beat_cnt == BCW'(RATIO - 1));
  assign last_word = (word_cnt == WCW'(WORDS_PER_LINE - 1));

  generate
    for (genvar i = 0; i < RATIO; i++) begin : g_slice
      l15_refill_beat_slice #(.W(BEAT_WIDTH)) u_slice (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat_acc && (beat_cnt == BCW'(i))),
        .d     (beat_data_i),
        .q     (buffer[i])
      );
    end
    // Write address stays inside the captured line: only word_cnt varies.
    if (LW > 0) begin : g_addr_line
      assign wr_addr = {base, word_cnt};
    end else begin : g_addr_word
      assign wr_addr = base;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      beat_cnt <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (refill_req_i) begin
          base     <= refill_addr_i[ADDR_WIDTH-1 -: BASE_W];
          beat_cnt <= '0;
          word_cnt <= '0;
          err      <= 1'b0;
        end
        COLLECT: if (beat_acc) begin
          err      <= err | beat_err_i;
          beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
        end
        WRITE: if (!last_word) word_cnt <= word_cnt + WCW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state;
    refill_gnt_o  = (state == IDLE);
    beat_ready_o  = (state == COLLECT);
    busy_o        = (state != IDLE);
    rd_gnt_o      = rd_req_i && (state != WRITE);
    mem_req_o     = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = rd_addr_i;
    mem_wdata_o   = buffer;
    mem_be_o      = '0;
    refill_done_o = 1'b0;
    refill_err_o  = 1'b0;

    case (state)
      IDLE:    if (refill_req_i) state_d = COLLECT;
      COLLECT: if (beat_acc && last_beat) state_d = WRITE;
      WRITE:   state_d = last_word ? IDLE : COLLECT;
      default: state_d = IDLE;
    endcase

    if (state == WRITE) begin
      mem_req_o     = 1'b1;
      mem_write_o   = 1'b1;
      mem_addr_o    = wr_addr;
      mem_be_o      = '1;
      // err already holds the final beat's flag: it was registered on acceptance.
      refill_done_o = last_word;
      refill_err_o  = last_word && err;
    end else if (rd_gnt_o) begin
      mem_req_o = 1'b1;
    end
  end
endmodule

// File: tb/tb_l15_data_refill_writer.sv
module tb_l15_data_refill_writer;
  localparam int DW = 128, BW = 64, AW = 7, WPL = 2;

  logic          clk = 1'b0, rst_n;
  logic          refill_req_i, refill_gnt_o;
  logic [AW-1:0] refill_addr_i;
  logic          beat_valid_i, beat_ready_o, beat_err_i;
  logic [BW-1:0] beat_data_i;
  logic          rd_req_i, rd_gnt_o;
  logic [AW-1:0] rd_addr_i;
  logic          mem_req_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW/8-1:0] mem_be_o;
  logic          refill_done_o, refill_err_o, busy_o;

  l15_data_refill_writer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst_n(rst_n),
    .refill_req_i(refill_req_i), .refill_gnt_o(refill_gnt_o), .refill_addr_i(refill_addr_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o), .beat_data_i(beat_data_i), .beat_err_i(beat_err_i),
    .rd_req_i(rd_req_i), .rd_gnt_o(rd_gnt_o), .rd_addr_i(rd_addr_i),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .refill_done_o(refill_done_o), .refill_err_o(refill_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111, D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333, D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D5 = 64'hAAAA_AAAA_AAAA_AAAA, D6 = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] D7 = 64'hCCCC_CCCC_CCCC_CCCC, D8 = 64'hDDDD_DDDD_DDDD_DDDD;

  typedef struct {
    logic rreq; logic [AW-1:0] raddr; logic bv; logic [BW-1:0] bd; logic berr; logic rd; logic [AW-1:0] rda;
    logic gnt, rdy, busy, rdgnt, mreq, mwr; logic [AW-1:0] maddr; logic [DW-1:0] wd; logic [15:0] be; logic done, err;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t vstart(input logic [AW-1:0] a, input logic rd, input logic [AW-1:0] rda);
    vec_t v = '{rreq:1, raddr:a, bv:0, bd:0, berr:0, rd:rd, rda:rda,
                gnt:1, rdy:0, busy:0, rdgnt:rd, mreq:rd, mwr:0, maddr:rda, wd:0, be:0, done:0, err:0};
    return v;
  endfunction

  function automatic vec_t vbeat(input logic [BW-1:0] d, input logic e, input logic rd, input logic [AW-1:0] rda);
    vec_t v = '{rreq:0, raddr:0, bv:1, bd:d, berr:e, rd:rd, rda:rda,
                gnt:0, rdy:1, busy:1, rdgnt:rd, mreq:rd, mwr:0, maddr:rda, wd:0, be:0, done:0, err:0};
    return v;
  endfunction

  function automatic vec_t vwrite(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic dn, input logic e,
                                  input logic rd, input logic bv, input logic [BW-1:0] bd);
    vec_t v = '{rreq:0, raddr:0, bv:bv, bd:bd, berr:0, rd:rd, rda:7'h03,
                gnt:0, rdy:0, busy:1, rdgnt:0, mreq:1, mwr:1, maddr:a, wd:wd, be:16'hFFFF, done:dn, err:e};
    return v;
  endfunction

  function automatic vec_t vidle();
    vec_t v = '{rreq:0, raddr:0, bv:0, bd:0, berr:0, rd:0, rda:0,
                gnt:1, rdy:0, busy:0, rdgnt:0, mreq:0, mwr:0, maddr:0, wd:0, be:0, done:0, err:0};
    return v;
  endfunction

  task automatic drive(input logic rreq, input logic [AW-1:0] ra, input logic bv, input logic [BW-1:0] bd,
                       input logic be, input logic rd, input logic [AW-1:0] rda);
    refill_req_i = rreq; refill_addr_i = ra; beat_valid_i = bv; beat_data_i = bd;
    beat_err_i = be; rd_req_i = rd; rd_addr_i = rda;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    @(negedge clk);
    drive(v.rreq, v.raddr, v.bv, v.bd, v.berr, v.rd, v.rda);
    #1;
    cmp($sformatf("v%0d gnt", k),   refill_gnt_o,  v.gnt);
    cmp($sformatf("v%0d ready", k), beat_ready_o,  v.rdy);
    cmp($sformatf("v%0d busy", k),  busy_o,        v.busy);
    cmp($sformatf("v%0d rd_gnt", k), rd_gnt_o,     v.rdgnt);
    cmp($sformatf("v%0d mem_req", k), mem_req_o,   v.mreq);
    cmp($sformatf("v%0d mem_write", k), mem_write_o, v.mwr);
    cmp($sformatf("v%0d done", k),  refill_done_o, v.done);
    cmp($sformatf("v%0d err", k),   refill_err_o,  v.err);
    if (v.mreq) begin
      cmp($sformatf("v%0d addr", k), mem_addr_o, v.maddr);
      cmp($sformatf("v%0d be", k),   mem_be_o,   v.be);
    end
    if (v.mwr) cmp($sformatf("v%0d wdata", k), mem_wdata_o, v.wd);
  endtask

  vec_t tbl[$];

  initial begin
    // refill 0x14, reads around the first WRITE
    tbl.push_back(vstart(7'h14, 0, 0));
    tbl.push_back(vbeat(D1, 0, 1, 7'h03));
    tbl.push_back(vbeat(D2, 0, 0, 0));
    tbl.push_back(vwrite(7'h14, {D2, D1}, 0, 0, 1, 1, D3));   // read refused, beat not taken
    tbl.push_back(vbeat(D3, 0, 1, 7'h03));                     // retried read granted
    tbl.push_back(vbeat(D4, 0, 0, 0));
    tbl.push_back(vwrite(7'h15, {D4, D3}, 1, 0, 0, 0, 0));
    tbl.push_back(vidle());
    // error on beat 2: both writes still happen, err reported with done
    tbl.push_back(vstart(7'h20, 0, 0));
    tbl.push_back(vbeat(D5, 0, 0, 0));
    tbl.push_back(vbeat(D6, 1, 0, 0));
    tbl.push_back(vwrite(7'h20, {D6, D5}, 0, 0, 0, 0, 0));
    tbl.push_back(vbeat(D7, 0, 0, 0));
    tbl.push_back(vbeat(D8, 0, 0, 0));
    tbl.push_back(vwrite(7'h21, {D8, D7}, 1, 1, 0, 0, 0));
    tbl.push_back(vidle());
    // clean refill at the top line, read granted in the start cycle
    tbl.push_back(vstart(7'h7E, 1, 7'h05));
    tbl.push_back(vbeat(D1, 0, 0, 0));
    tbl.push_back(vbeat(D2, 0, 0, 0));
    tbl.push_back(vwrite(7'h7E, {D2, D1}, 0, 0, 0, 0, 0));
    tbl.push_back(vbeat(D3, 0, 0, 0));
    tbl.push_back(vbeat(D4, 0, 0, 0));
    tbl.push_back(vwrite(7'h7F, {D4, D3}, 1, 0, 0, 0, 0));
    tbl.push_back(vidle());

    // reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    cmp("rst gnt", refill_gnt_o, 1'b1);
    cmp("rst ready", beat_ready_o, 1'b0);
    cmp("rst mem_req", mem_req_o, 1'b0);
    cmp("rst done", refill_done_o, 1'b0);
    cmp("rst busy", busy_o, 1'b0);
    rd_req_i = 1'b1; #1;
    cmp("rst mem_req follows rd", mem_req_o, 1'b1);
    cmp("rst mem_write", mem_write_o, 1'b0);
    rd_req_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k], k);

    // random beat gaps with refill_req held throughout
    begin
      logic [BW-1:0] dq[4];
      logic [DW-1:0] ew[2];
      int idx = 0, wi = 0, finished = 0;
      logic bv;
      dq = '{D1, D2, D3, D4};
      ew = '{{D2, D1}, {D4, D3}};
      for (int cyc = 0; cyc < 200 && finished == 0; cyc++) begin
        @(negedge clk);
        bv = (idx < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive(1, 7'h14, bv, (idx < 4) ? dq[idx] : '0, 0, 0, 0);
        #1;
        cmp("gap gnt", refill_gnt_o, (cyc == 0) ? 1'b1 : 1'b0);
        if (beat_ready_o && bv) idx++;
        if (mem_write_o) begin
          if (wi < 2) begin
            cmp("gap addr", mem_addr_o, 7'h14 + 7'(wi));
            cmp("gap wdata", mem_wdata_o, ew[wi]);
          end
          wi++;
        end
        if (refill_done_o) begin
          cmp("gap writes", wi, 2);
          cmp("gap err", refill_err_o, 1'b0);
          finished = 1;
        end
      end
      if (finished == 0) begin
        checks++; errors++;
        $display("FAIL gap timeout: got no done, expected done within 200 cycles");
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      cmp("gap back to idle gnt", refill_gnt_o, 1'b1);
    end

    // reset mid-refill after 3 beats
    begin
      int bad = 0;
      @(negedge clk); drive(1, 7'h14, 0, 0, 0, 0, 0);
      @(negedge clk); drive(0, 0, 1, D1, 0, 0, 0);
      @(negedge clk); drive(0, 0, 1, D2, 0, 0, 0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);       // WRITE of word 0
      @(negedge clk); drive(0, 0, 1, D3, 0, 0, 0);
      @(negedge clk); drive(0, 0, 1, D4, 0, 1, 7'h09);
      rst_n = 1'b0; #1;
      cmp("mid-rst busy", busy_o, 1'b0);
      cmp("mid-rst gnt", refill_gnt_o, 1'b1);
      cmp("mid-rst ready", beat_ready_o, 1'b0);
      cmp("mid-rst mem_write", mem_write_o, 1'b0);
      cmp("mid-rst mem_req", mem_req_o, 1'b1);
      @(negedge clk); rst_n = 1'b1; drive(0, 0, 1, D4, 0, 0, 0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk); #1;
        if (mem_write_o || refill_done_o) bad++;
      end
      cmp("post-rst no write/done", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
